// File: rtl/spi_pixel_slave_if.sv
// Pixel-word bus between the SPI deserialiser and the HUB75 pixel path.
// The slave drives data/pixel_clk; spi_mosi arrives from the SPI master.
interface spi_pixel_slave_if #(
    parameter int WORD_WIDTH = 16
);
    logic                  spi_mosi;
    logic [WORD_WIDTH-1:0] data;
    logic                  pixel_clk;

    modport slave (
        input  spi_mosi,
        output data,
        output pixel_clk
    );

    modport master (
        output spi_mosi,
        input  data,
        input  pixel_clk
    );
endinterface

// File: rtl/spi_pixel_slave.sv
// Receive-only SPI slave: deserialises MOSI into WORD_WIDTH-bit words, one strobe per word.
// Latency: word and strobe registered on the edge that samples its last bit; no backpressure.
// Optional SPI_SLAVE_LSB_FIRST_EN: LSB-first bit order (default MSB first).
module spi_pixel_slave #(
    parameter int WORD_WIDTH = 16
) (
    input  logic             spi_clk,
    input  logic             reset,
    spi_pixel_slave_if.slave bus
);
    localparam int CW = (WORD_WIDTH > 2) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WORD_WIDTH - 1);

    logic [WORD_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_cnt;
    logic [WORD_WIDTH-1:0] r_data;
    logic                  r_pixel_clk;
    logic [WORD_WIDTH-1:0] w_shift_nxt;
    logic                  w_word_done;

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign w_shift_nxt = {bus.spi_mosi, r_shift[WORD_WIDTH-1:1]};
`else
    assign w_shift_nxt = {r_shift[WORD_WIDTH-2:0], bus.spi_mosi};
`endif

    assign w_word_done = (r_cnt == LAST_BIT);

    always_ff @(posedge spi_clk or negedge reset) begin
        if (!reset) begin
            r_shift     <= '0;
            r_cnt       <= '0;
            r_data      <= '0;
            r_pixel_clk <= 1'b0;
        end else begin
            r_shift     <= w_shift_nxt;
            r_pixel_clk <= w_word_done;
            if (w_word_done) begin
                // Data includes the bit sampled on this very edge.
                r_data <= w_shift_nxt;
                r_cnt  <= '0;
            end else begin
                r_cnt  <= r_cnt + CW'(1);
            end
        end
    end

    assign bus.data      = r_data;
    assign bus.pixel_clk = r_pixel_clk;
endmodule

// File: tb/tb_spi_pixel_slave.sv
// Directed bench for spi_pixel_slave (16-bit words); honours SPI_SLAVE_LSB_FIRST_EN.
module tb_spi_pixel_slave;
    logic spi_clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    spi_pixel_slave_if #(.WORD_WIDTH(16)) bus ();

    spi_pixel_slave #(.WORD_WIDTH(16)) dut (
        .spi_clk (spi_clk),
        .reset   (reset),
        .bus     (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Wire order is always MSB first; an LSB-first slave sees the word bit-reversed.
    function automatic logic [15:0] exp_word(input logic [15:0] w);
        logic [15:0] r;
`ifdef SPI_SLAVE_LSB_FIRST_EN
        for (int i = 0; i < 16; i++) r[i] = w[15-i];
`else
        r = w;
`endif
        return r;
    endfunction

    // One bit per rising edge; sample outputs 1 time unit after the edge.
    task automatic clk_bit(input logic b);
        bus.spi_mosi = b;
        #4 spi_clk = 1'b1;
        #1;
    endtask

    task automatic clk_fall();
        #4 spi_clk = 1'b0;
        #1;
    endtask

    // Send n bits of val MSB first; checks every edge. done: the last edge completes a word.
    task automatic send_bits(input string name, input logic [15:0] val, input int n,
                             input logic [15:0] hold, input bit done, input logic [15:0] word);
        for (int i = 0; i < n; i++) begin
            logic last;
            clk_bit(val[n-1-i]);
            last = done && (i == n - 1);
            check($sformatf("%s pix e%0d", name, i + 1), {31'd0, bus.pixel_clk}, {31'd0, last});
            check($sformatf("%s dat e%0d", name, i + 1), {16'd0, bus.data},
                  {16'd0, (last ? word : hold)});
            clk_fall();
        end
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        spi_clk      = 1'b0;
        reset        = 1'b0;
        bus.spi_mosi = 1'b1;
        #3;
        check("rst dat", {16'd0, bus.data}, 32'd0);
        check("rst pix", {31'd0, bus.pixel_clk}, 32'd0);

        // Clocks while held in reset must not move anything.
        for (int i = 0; i < 5; i++) begin
            clk_bit(1'b1);
            check($sformatf("rsthold dat %0d", i), {16'd0, bus.data}, 32'd0);
            check($sformatf("rsthold pix %0d", i), {31'd0, bus.pixel_clk}, 32'd0);
            clk_fall();
        end
        reset = 1'b1;
        #5;

        // Multi-word stream deadbeef0000.
        send_bits("s0", 16'hdead, 16, 16'h0000, 1'b1, exp_word(16'hdead));
        send_bits("s1", 16'hbeef, 16, exp_word(16'hdead), 1'b1, exp_word(16'hbeef));
        send_bits("s2", 16'h0000, 16, exp_word(16'hbeef), 1'b1, 16'h0000);

        // Partial word then asynchronous reset mid-word.
        send_bits("part", 16'h00a5, 8, 16'h0000, 1'b0, 16'h0000);
        reset = 1'b0;
        #2;
        check("midrst dat", {16'd0, bus.data}, 32'd0);
        check("midrst pix", {31'd0, bus.pixel_clk}, 32'd0);
        #3 reset = 1'b1;
        #5;
        send_bits("r1234", 16'h1234, 16, 16'h0000, 1'b1, exp_word(16'h1234));

        // Idle between halves of a word.
        send_bits("idle_a", 16'h00ca, 8, exp_word(16'h1234), 1'b0, 16'h0000);
        #100;
        check("idle pix", {31'd0, bus.pixel_clk}, 32'd0);
        send_bits("idle_b", 16'h00fe, 8, exp_word(16'h1234), 1'b1, exp_word(16'hcafe));

        // Back-to-back extremes.
        send_bits("ffff", 16'hffff, 16, exp_word(16'hcafe), 1'b1, 16'hffff);
        send_bits("0001", 16'h0001, 16, 16'hffff, 1'b1, exp_word(16'h0001));

`ifdef SPI_SLAVE_LSB_FIRST_EN
        send_bits("lsb", 16'hdead, 16, exp_word(16'h0001), 1'b1, 16'hb57b);
`else
        send_bits("msb", 16'hdead, 16, 16'h0001, 1'b1, 16'hdead);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
